// File: rtl/config_pkg.sv
// Shared types and constants for the fabric configuration loader
// and the tile-side address decoders.
package config_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_STROBE,
        ST_DONE
    } cfg_state_e;

    localparam logic [31:0] CFG_TERMINATOR = 32'hFFFF_FFFF;

    localparam int CFG_COMP_W = 16;
    localparam int CFG_TILE_W = 16;
    localparam int CFG_ADDR_W = CFG_COMP_W + CFG_TILE_W;

    localparam logic [CFG_COMP_W-1:0] CFG_COMP_CLB = 16'd5;
    localparam logic [CFG_COMP_W-1:0] CFG_COMP_CB  = 16'd6;
    localparam logic [CFG_COMP_W-1:0] CFG_COMP_SB  = 16'd7;

endpackage

// File: rtl/config_loader.sv
// Streams address/data pairs onto the tile configuration bus.
// Optional checksum at the terminator: CONFIG_LOADER_CHECKSUM_EN.
module config_loader
    import config_pkg::*;
#(
    parameter int HOLD_CYCLES = 1,
    parameter int COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [31:0]        in_word,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [31:0]        config_addr,
    output logic [31:0]        config_data,
    output logic               config_en,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] word_count,
    output logic               error
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    cfg_state_e            state_q;
    cfg_state_e            state_d;
    logic [CFG_ADDR_W-1:0] addr_q;
    logic [3:0]            hold_q;
    logic                  done_q;

    logic arm;
    logic load_addr;
    logic bus_write;
    logic term_hit;
    logic strobe_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // in_ready is a pure state decode; in_valid only steers the next state
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        config_en  = 1'b0;
        busy       = 1'b0;
        arm        = 1'b0;
        load_addr  = 1'b0;
        bus_write  = 1'b0;
        term_hit   = 1'b0;
        strobe_end = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    arm     = 1'b1;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    load_addr = 1'b1;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    if (addr_q == CFG_TERMINATOR) begin
                        term_hit = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        bus_write = 1'b1;
                        state_d   = ST_STROBE;
                    end
                end
            end
            ST_STROBE: begin
                config_en = 1'b1;
                busy      = 1'b1;
                if (hold_q == HOLD_LAST) begin
                    strobe_end = 1'b1;
                    state_d    = ST_ADDR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= '0;
            hold_q      <= '0;
            config_addr <= '0;
            config_data <= '0;
            word_count  <= '0;
            done_q      <= 1'b0;
        end else begin
            if (arm) begin
                word_count <= '0;
                done_q     <= 1'b0;
            end
            if (load_addr) begin
                addr_q <= in_word;
            end
            if (bus_write) begin
                config_addr <= addr_q;
                config_data <= in_word;
            end
            if (term_hit) begin
                done_q <= 1'b1;
            end
            if (strobe_end && (word_count != '1)) begin
                word_count <= word_count + 1'b1;
            end
            if (bus_write) begin
                hold_q <= '0;
            end else if (state_q == ST_STROBE) begin
                hold_q <= hold_q + 4'd1;
            end
        end
    end

    assign done = done_q;

`ifdef CONFIG_LOADER_CHECKSUM_EN
    logic [31:0] csum_q;
    logic        error_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q  <= '0;
            error_q <= 1'b0;
        end else begin
            if (arm) begin
                csum_q  <= '0;
                error_q <= 1'b0;
            end
            if (bus_write) begin
                csum_q <= csum_q ^ in_word;
            end
            if (term_hit) begin
                error_q <= (csum_q != in_word);
            end
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader with a transaction-level model
// and a per-cycle bus monitor.
module tb_config_loader;

    localparam int HOLD = 3;
    localparam int CW   = 16;
    localparam logic [31:0] TERM = 32'hFFFF_FFFF;
`ifdef CONFIG_LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   in_word = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   config_addr;
    logic [31:0]   config_data;
    logic          config_en;
    logic          busy;
    logic          done;
    logic [CW-1:0] word_count;
    logic          error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    config_loader #(
        .HOLD_CYCLES(HOLD),
        .COUNT_W    (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_word    (in_word),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .config_addr(config_addr),
        .config_data(config_data),
        .config_en  (config_en),
        .busy       (busy),
        .done       (done),
        .word_count (word_count),
        .error      (error)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] m_xor;
    int          m_count;
    bit          m_done;
    bit          m_err;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus monitor: every strobe must match the next expected write
    bit          prev_en = 1'b0;
    int          en_len = 0;
    logic [31:0] cur_a;
    logic [31:0] cur_d;
    wr_t         w;

    always @(negedge clk) begin
        if (reset) begin
            prev_en = 1'b0;
            en_len  = 0;
        end else begin
            if (config_en) begin
                check("ready_in_strobe", in_ready, 0);
                if (!prev_en) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_write: addr %h data %h",
                                 config_addr, config_data);
                    end else begin
                        w = exp_q.pop_front();
                        check("wr_addr", config_addr, w.a);
                        check("wr_data", config_data, w.d);
                    end
                    cur_a = config_addr;
                    cur_d = config_data;
                end else begin
                    check("addr_stable", config_addr, cur_a);
                    check("data_stable", config_data, cur_d);
                end
                en_len++;
            end else if (prev_en) begin
                check("hold_len", en_len, HOLD);
                en_len = 0;
            end
            prev_en = config_en;
            check("done_vs_busy", done & busy, 0);
        end
    end

    task automatic send_word(input logic [31:0] wd, input int stall);
        bit got;
        bit ok;
        ok = 1'b0;
        in_valid = 1'b0;
        repeat (stall) begin
            in_word = $urandom;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_word  = wd;
        for (int i = 0; i < 100; i++) begin
            got = in_ready;
            @(posedge clk);
            #1;
            if (got) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: word %h never accepted", wd);
        end
        in_valid = 1'b0;
        in_word  = $urandom;
    endtask

    task automatic model_pair(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        if (a == TERM) begin
            m_done = 1'b1;
            m_err  = CSUM ? (m_xor != d) : 1'b0;
        end else begin
            e.a = a;
            e.d = d;
            exp_q.push_back(e);
            m_xor = m_xor ^ d;
            m_count++;
        end
    endtask

    task automatic send_pair(input logic [31:0] a, input logic [31:0] d,
                             input int stall);
        model_pair(a, d);
        send_word(a, stall);
        send_word(d, stall);
    endtask

    task automatic begin_seq();
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        m_xor   = '0;
        m_count = 0;
        m_done  = 1'b0;
        m_err   = 1'b0;
        @(negedge clk);
        check("arm_ready", in_ready, 1);
        check("arm_busy", busy, 1);
        check("arm_done", done, 0);
        check("arm_error", error, 0);
        check("arm_count", word_count, 0);
    endtask

    task automatic end_seq();
        @(negedge clk);
        check("seq_done", done, m_done);
        check("seq_error", error, m_err);
        check("seq_count", word_count, m_count);
        check("seq_busy", busy, 0);
        check("seq_ready", in_ready, 0);
        check("seq_pending", exp_q.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_addr"}, config_addr, 0);
        check({tag, "_data"}, config_data, 0);
        check({tag, "_en"}, config_en, 0);
        check({tag, "_ready"}, in_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_count"}, word_count, 0);
        check({tag, "_error"}, error, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_zero("rst");
        @(negedge clk);
        check("idle_no_ready", in_ready, 0);

        // Single write, matching checksum
        begin_seq();
        send_pair(32'h0007_0003, 32'h0000_00A5, 0);
        send_pair(TERM, 32'h0000_00A5, 0);
        end_seq();
        check("single_addr", config_addr, 32'h0007_0003);
        check("single_data", config_data, 32'h0000_00A5);
        check("single_count", word_count, 1);
        check("single_error", error, 0);

        // Backpressure over three pairs
        begin_seq();
        send_pair(32'h0007_0010, 32'hDEAD_BEEF, $urandom_range(0, 3));
        send_pair(32'h0006_0011, 32'h1234_5678, $urandom_range(0, 3));
        send_pair(32'h0005_0012, 32'h0F0F_F0F0, $urandom_range(0, 3));
        send_pair(TERM, m_xor, $urandom_range(0, 3));
        end_seq();
        check("bp_count", word_count, 3);
        check("bp_addr", config_addr, 32'h0005_0012);

        // Checksum mismatch: 1^2^4 = 7, terminator carries 6
        begin_seq();
        send_pair(32'h0007_0001, 32'h1, 0);
        send_pair(32'h0007_0002, 32'h2, 1);
        send_pair(32'h0007_0003, 32'h4, 0);
        send_pair(TERM, 32'h6, 0);
        end_seq();
        check("csum_bad", error, CSUM ? 1 : 0);
        @(negedge clk);
        check("csum_sticky", error, CSUM ? 1 : 0);

        // Checksum match clears on re-arm
        begin_seq();
        send_pair(32'h0007_0001, 32'h1, 0);
        send_pair(32'h0007_0002, 32'h2, 0);
        send_pair(32'h0007_0003, 32'h4, 2);
        send_pair(TERM, 32'h7, 0);
        end_seq();
        check("csum_good", error, 0);

        // start pulsed in DATA is ignored
        begin_seq();
        send_pair(32'h0006_0020, 32'hAAAA_0001, 0);
        model_pair(32'h0006_0021, 32'hAAAA_0002);
        send_word(32'h0006_0021, 0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("ign_start_count", word_count, 1);
        check("ign_start_ready", in_ready, 1);
        send_word(32'hAAAA_0002, 0);
        send_pair(TERM, m_xor, 0);
        end_seq();
        check("ign_start_final", word_count, 2);

        // Reset in the second strobe cycle
        begin_seq();
        model_pair(32'h0007_0030, 32'h5555_5555);
        send_word(32'h0007_0030, 0);
        send_word(32'h5555_5555, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_zero("midrst");
        check("midrst_pending", exp_q.size(), 0);
        @(negedge clk);
        check("midrst_idle", in_ready, 0);

        begin_seq();
        send_pair(32'h0007_0031, 32'h6666_6666, 0);
        send_pair(TERM, 32'h6666_6666, 0);
        end_seq();
        check("reload_addr", config_addr, 32'h0007_0031);
        check("reload_count", word_count, 1);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/config_loader.md
# config_loader

Sequences the fabric configuration bus for an array of PE tiles. Accepts a stream of 32-bit words (address/data pairs) from a host-side valid/ready source and drives each pair onto the shared `config_addr`/`config_data` bus with a timed `config_en` strobe. Each tile decodes the address against its `tile_id` and component field. The block sits between the host loader (or bitstream ROM) and the tile array, one instance per array.

## Interface
Parameters:
- `HOLD_CYCLES`, 1: cycles `config_en` stays high per write; legal values are 1..15.
- `COUNT_W`, 16: width of `word_count`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle pulse that arms the loader.
- `in_word`  in  32  stream word, alternating address then data.
- `in_valid`  in  1  `in_word` is valid.
- `in_ready`  out  1  loader accepts `in_word` this cycle.
- `config_addr`  out  32  bits [31:16] are the component ID (switch box = 7); bits [15:0] are the tile ID.
- `config_data`  out  32  configuration payload.
- `config_en`  out  1  write strobe to the tiles.
- `busy`  out  1  high in ADDR, DATA or STROBE.
- `done`  out  1  terminator consumed; sticky until the next `start`.
- `word_count`  out  COUNT_W  number of completed bus writes; saturates at the maximum value.
- `error`  out  1  checksum mismatch at the terminator (see Configuration).

## Operation
- The FSM has states IDLE, ADDR, DATA, STROBE and DONE. Reset enters IDLE.
- IDLE and DONE:
  - `in_ready`=0.
  - `start` goes to ADDR and clears `word_count`, `done`, `error` and the checksum.
- ADDR:
  - `in_ready`=1.
  - On handshake (`in_valid`&`in_ready`), latch the address internally and go to DATA.
- DATA:
  - `in_ready`=1.
  - On handshake with a latched address != 32'hFFFF_FFFF:
    - load `config_addr` and `config_data`;
    - XOR the data into the checksum;
    - go to STROBE.
  - On handshake with the terminator address (32'hFFFF_FFFF):
    - the data word is the expected checksum;
    - no bus write occurs;
    - go to DONE and set `done`.
- STROBE:
  - `in_ready`=0 and `config_en`=1 for exactly `HOLD_CYCLES` cycles.
  - Then increment `word_count` (saturating) and return to ADDR.
- `config_addr` and `config_data` hold their last written value until the next DATA handshake. They never change while `config_en`=1.
- A `start` pulse in ADDR, DATA or STROBE is ignored.
- `in_valid` low in ADDR or DATA stalls indefinitely with no timeout.
- A reset in any state, including mid-strobe, returns to IDLE and zeroes every output on that edge. A partially received pair is discarded.

## Timing
- Reset values: every output is 0, including `config_addr` and `config_data`.
- `in_ready` is a registered state decode and never depends on `in_valid` combinationally.
- DATA handshake at edge N: `config_en` is high in cycles N+1 .. N+HOLD_CYCLES; `config_addr`/`config_data` are valid from N+1.
- `word_count` updates on the edge that ends the strobe, in the same cycle `in_ready` returns to 1.
- Peak throughput is one write per 2+HOLD_CYCLES cycles.
- The terminator data handshake at edge N gives `done`=1 (and `error`, if enabled) from N+1. `busy` falls at N+1.
- `start` is sampled only in IDLE or DONE. It takes effect on the next edge: `in_ready`=1 from that edge.

## Configuration
- Macro: `CONFIG_LOADER_CHECKSUM_EN`.
- Defined:
  - maintain a 32-bit XOR of all written data words;
  - at the terminator, `error` = (checksum != terminator data);
  - `error` is sticky until `start` or `reset`.
- Undefined:
  - no checksum register is built;
  - the terminator data word is consumed and ignored;
  - `error` is tied to 0.
- The port list is identical in both builds.

## Structure
- Shared package `config_pkg`:
  - the FSM state enum;
  - `CFG_TERMINATOR` = 32'hFFFF_FFFF;
  - the component ID constants (`CFG_COMP_SB` = 7, the connect-box and CLB IDs);
  - address field widths for the component [31:16] and tile [15:0] fields.
- No sub-module. The hold counter (4 bits) and the checksum live inline in one module.

## Test plan
- Single write:
  - Stimulus: `start`, then words 0x0007_0003, 0x0000_00A5, then terminator FFFF_FFFF/0x0000_00A5.
  - Response: one `config_en` pulse with `config_addr`=0x0007_0003 and `config_data`=0xA5; `word_count`=1; `done`=1; `error`=0.
- Hold length:
  - Stimulus: `HOLD_CYCLES`=3, one write.
  - Response: `config_en` is high for exactly 3 cycles; `in_ready` is 0 during them; bus values are stable throughout.
- Backpressure and stalls:
  - Stimulus: `in_valid` toggled randomly over 3 pairs.
  - Response: exactly 3 strobes, in order, with the correct addr/data; no word is dropped or duplicated.
- Checksum (macro defined):
  - Stimulus: data 0x1, 0x2, 0x4, then a terminator carrying 0x6.
  - Response: `error`=1; with 0x7 instead, `error`=0.
  - With the macro undefined, `error` stays 0.
- Reset mid-strobe:
  - Stimulus: `reset` in the second cycle of `HOLD_CYCLES`=3.
  - Response: the next cycle has all outputs 0 and the FSM in IDLE; a later `start` reloads correctly.
- Ignored start:
  - Stimulus: `start` pulsed during DATA.
  - Response: no effect; `word_count` is not cleared and the sequence completes normally.
